// File: rtl/pipe_stage_chain.sv
`timescale 1ns/1ps
// Elastic chain of STAGES valid/data registers; per-stage stall/flush, bubbles collapse toward the exit.
// Latency STAGES edges through an empty chain; o_ready drops when stage 0 cannot advance or any flush is active.
module pipe_stage_chain #(
   parameter int STAGES = 4,
   parameter int DATA_W = 32
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [DATA_W-1:0]            i_data,
   input  logic [STAGES-1:0]            i_stall,
   input  logic [STAGES-1:0]            i_flush,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [DATA_W-1:0]            o_data,
   output logic [STAGES-1:0]            o_stage_valid,
   output logic [STAGES*DATA_W-1:0]     o_stage_data,
   output logic [$clog2(STAGES+1)-1:0]  o_occupancy
);

   localparam int OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0] r_valid;
   logic [DATA_W-1:0] r_data [STAGES];
   logic [OCC_W-1:0]  r_occupancy;

   logic [STAGES-1:0] w_kill;
   logic [STAGES-1:0] w_ev;
   logic [STAGES-1:0] w_move;
   logic [STAGES-1:0] w_acc;
   logic [STAGES-1:0] w_load;
   logic [STAGES-1:0] w_valid_nxt;
   logic [DATA_W-1:0] w_din [STAGES];

   // Walk from the oldest stage down so acceptance ripples toward the entry in one pass.
   always_comb begin : p_ctrl
      logic w_kill_up;
      logic w_acc_up;
      w_kill_up = 1'b0;
      w_acc_up  = i_ready;
      w_kill    = '0;
      w_ev      = '0;
      w_move    = '0;
      w_acc     = '0;
      for (int k = STAGES-1; k >= 0; k--) begin
         w_kill_up = w_kill_up | i_flush[k];
         w_kill[k] = w_kill_up;
         w_ev[k]   = r_valid[k] & ~w_kill_up;
         w_move[k] = w_ev[k] & ~i_stall[k] & w_acc_up;
         w_acc[k]  = ~r_valid[k] | w_move[k];
         w_acc_up  = w_acc[k];
      end
   end

   assign o_ready = w_acc[0] & ~(|i_flush);
   assign w_load  = {w_move[STAGES-2:0], i_valid & o_ready};

   assign w_din[0] = i_data;
   for (genvar k = 1; k < STAGES; k++) begin : g_din
      assign w_din[k] = r_data[k-1];
   end

   always_comb begin
      w_valid_nxt = r_valid;
      for (int k = 0; k < STAGES; k++) begin
         if (w_load[k]) begin
            w_valid_nxt[k] = 1'b1;
         end else if (w_kill[k] | w_move[k]) begin
            w_valid_nxt[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_valid     <= '0;
         r_occupancy <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         r_valid     <= w_valid_nxt;
         r_occupancy <= OCC_W'($countones(w_valid_nxt));
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_data[k] <= w_din[k];
            end
         end
      end
   end

   assign o_valid       = w_ev[STAGES-1] & ~i_stall[STAGES-1];
   assign o_data        = r_data[STAGES-1];
   assign o_stage_valid = r_valid;
   assign o_occupancy   = r_occupancy;

   for (genvar k = 0; k < STAGES; k++) begin : g_flat
      assign o_stage_data[k*DATA_W +: DATA_W] = r_data[k];
   end

   a_occ_bound : assert property (@(posedge i_clk) disable iff (!i_reset)
      r_occupancy <= OCC_W'(STAGES));
   a_no_accept_on_flush : assert property (@(posedge i_clk) disable iff (!i_reset)
      o_ready |-> ~(|i_flush));
   a_hold_output : assert property (@(posedge i_clk) disable iff (!i_reset)
      (o_valid && !i_ready) |=> $stable(o_data));

endmodule

// File: tb/tb_pipe_stage_chain.sv
`timescale 1ns/1ps
// Bench for pipe_stage_chain: per-scenario tasks with inline checks plus a queue scoreboard on the output port.
module tb_pipe_stage_chain;

   localparam int STAGES = 4;
   localparam int DATA_W = 32;

   logic                        i_clk   = 1'b0;
   logic                        i_reset = 1'b0;
   logic                        i_valid = 1'b0;
   logic                        i_ready = 1'b1;
   logic [DATA_W-1:0]           i_data  = '0;
   logic [STAGES-1:0]           i_stall = '0;
   logic [STAGES-1:0]           i_flush = '0;
   logic                        o_ready;
   logic                        o_valid;
   logic [DATA_W-1:0]           o_data;
   logic [STAGES-1:0]           o_stage_valid;
   logic [STAGES*DATA_W-1:0]    o_stage_data;
   logic [2:0]                  o_occupancy;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   logic [DATA_W-1:0] q [$];
   logic [DATA_W-1:0] mon_exp;

   pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_data        (i_data),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_data        (o_data),
      .o_stage_valid (o_stage_valid),
      .o_stage_data  (o_stage_data),
      .o_occupancy   (o_occupancy)
   );

   always #5 i_clk = ~i_clk;

   // Scoreboard: accepted words are pushed, exiting words are popped and compared.
   always @(negedge i_clk) begin
      if (i_reset) begin
         if (o_valid && i_ready) begin
            checks++;
            n_out++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow: got %0h, expected no output", o_data);
            end else begin
               mon_exp = q.pop_front();
               if (o_data !== mon_exp) begin
                  errors++;
                  $display("FAIL scoreboard_data: got %0h, expected %0h", o_data, mon_exp);
               end
            end
         end
         if (i_valid && o_ready) q.push_back(i_data);
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
      #1;
   endtask

   task automatic drain(input string tag);
      tick();
      i_valid = 1'b0;
      i_stall = '0;
      i_flush = '0;
      i_ready = 1'b1;
      repeat (STAGES + 2) tick();
      smp();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain_queue: got %0d pending, expected 0", tag, q.size());
      end
      checks++;
      if (o_occupancy !== 3'd0) begin
         errors++;
         $display("FAIL %s_drain_occ: got %0d, expected 0", tag, o_occupancy);
      end
   endtask

   task automatic fill(input logic [DATA_W-1:0] base);
      for (int i = 0; i < STAGES; i++) begin
         tick();
         i_ready = 1'b0;
         i_valid = 1'b1;
         i_data  = base + DATA_W'(i);
         smp();
         checks++;
         if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready: got %0b, expected 1", o_ready);
         end
      end
      tick();
      i_valid = 1'b0;
      smp();
      checks++;
      if (o_stage_valid !== 4'hF || o_occupancy !== 3'd4 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: got sv=%0h occ=%0d rdy=%0b, expected sv=f occ=4 rdy=0",
                  o_stage_valid, o_occupancy, o_ready);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_occupancy !== 3'd0 || o_stage_valid !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: got v=%0b r=%0b occ=%0d sv=%0h, expected 0 1 0 0",
                  o_valid, o_ready, o_occupancy, o_stage_valid);
      end
      checks++;
      if (o_stage_data !== '0 || o_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got %0h, expected 0", o_stage_data);
      end
      #10;
      i_reset = 1'b1;
   endtask

   task automatic test_stream();
      logic       exp_v;
      logic [2:0] exp_occ;
      int         n_acc, n_ex;
      i_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         i_valid = (i < 8);
         i_data  = DATA_W'(i + 1);
         smp();
         exp_v = (i >= 4 && i <= 11);
         n_acc = (i < 8) ? i : 8;
         n_ex  = (i > 4) ? i - 4 : 0;
         exp_occ = 3'(n_acc - n_ex);
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL stream_valid[%0d]: got %0b, expected %0b", i, o_valid, exp_v);
         end
         checks++;
         if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready[%0d]: got %0b, expected 1", i, o_ready);
         end
         checks++;
         if (o_occupancy !== exp_occ) begin
            errors++;
            $display("FAIL stream_occ[%0d]: got %0d, expected %0d", i, o_occupancy, exp_occ);
         end
      end
      drain("stream");
   endtask

   task automatic test_stall();
      logic [5:0] exp_v = 6'b110011;
      logic [5:0] exp_r = 6'b111100;
      fill(32'hA0);
      for (int c = 0; c < 6; c++) begin
         tick();
         i_ready = 1'b1;
         i_stall = (c < 2) ? 4'b0010 : 4'b0000;
         smp();
         checks++;
         if (o_valid !== exp_v[c] || o_ready !== exp_r[c]) begin
            errors++;
            $display("FAIL stall_cycle[%0d]: got v=%0b r=%0b, expected v=%0b r=%0b",
                     c, o_valid, o_ready, exp_v[c], exp_r[c]);
         end
         if (c == 1) begin
            checks++;
            if (o_stage_valid !== 4'b1011 || o_stage_data[1*DATA_W +: DATA_W] !== 32'hA2) begin
               errors++;
               $display("FAIL stall_hold: got sv=%0h s1=%0h, expected sv=b s1=a2",
                        o_stage_valid, o_stage_data[1*DATA_W +: DATA_W]);
            end
         end
         if (c == 2) begin
            checks++;
            if (o_stage_valid !== 4'b0011) begin
               errors++;
               $display("FAIL stall_bubble: got sv=%0h, expected 3", o_stage_valid);
            end
         end
      end
      drain("stall");
   endtask

   task automatic test_flush();
      int n0;
      fill(32'hB0);
      n0 = n_out;
      tick();
      i_flush = 4'b0010;
      void'(q.pop_back());
      void'(q.pop_back());
      smp();
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'hB0) begin
         errors++;
         $display("FAIL flush_cycle: got r=%0b v=%0b d=%0h, expected r=0 v=1 d=b0", o_ready, o_valid, o_data);
      end
      tick();
      i_flush = '0;
      smp();
      checks++;
      if (o_occupancy !== 3'd2 || o_stage_valid !== 4'b1100) begin
         errors++;
         $display("FAIL flush_after: got occ=%0d sv=%0h, expected occ=2 sv=c", o_occupancy, o_stage_valid);
      end
      tick();
      i_ready = 1'b1;
      smp();
      tick();
      smp();
      checks++;
      if (o_occupancy !== 3'd1 || o_stage_valid !== 4'b1000 || o_data !== 32'hB1) begin
         errors++;
         $display("FAIL flush_drop: got occ=%0d sv=%0h d=%0h, expected occ=1 sv=8 d=b1",
                  o_occupancy, o_stage_valid, o_data);
      end
      drain("flush");
      checks++;
      if (n_out - n0 !== 2) begin
         errors++;
         $display("FAIL flush_count: got %0d words, expected 2", n_out - n0);
      end
      // A flush on an empty chain must still refuse the entry word.
      tick();
      i_valid = 1'b1;
      i_data  = 32'hEE;
      i_flush = 4'b1000;
      smp();
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty_ready: got %0b, expected 0", o_ready);
      end
      tick();
      i_valid = 1'b0;
      i_flush = '0;
      smp();
      checks++;
      if (o_occupancy !== 3'd0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty_after: got occ=%0d r=%0b, expected occ=0 r=1", o_occupancy, o_ready);
      end
   endtask

   task automatic test_backpressure();
      tick();
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = 32'hC0;
      smp();
      tick();
      i_valid = 1'b0;
      repeat (2) tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         i_valid = 1'b1;
         i_data  = 32'h10 + DATA_W'((c < 3) ? c : 3);
         smp();
         if (c == 0) begin
            checks++;
            if (o_stage_valid !== 4'b1000) begin
               errors++;
               $display("FAIL bp_start: got sv=%0h, expected 8", o_stage_valid);
            end
         end
         checks++;
         if (o_ready !== (c < 3)) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %0b, expected %0b", c, o_ready, (c < 3));
         end
         checks++;
         if (o_valid !== 1'b1 || o_data !== 32'hC0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%0b d=%0h, expected v=1 d=c0", c, o_valid, o_data);
         end
         if (c == 3) begin
            checks++;
            if (o_occupancy !== 3'd4) begin
               errors++;
               $display("FAIL bp_occ: got %0d, expected 4", o_occupancy);
            end
         end
      end
      tick();
      i_valid = 1'b0;
      drain("backpressure");
   endtask

   task automatic test_flush_beats_stall();
      fill(32'hD0);
      tick();
      i_stall = 4'b0100;
      i_flush = 4'b0100;
      i_ready = 1'b1;
      repeat (3) void'(q.pop_back());
      smp();
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 32'hD0) begin
         errors++;
         $display("FAIL fbs_cycle: got v=%0b r=%0b d=%0h, expected v=1 r=0 d=d0", o_valid, o_ready, o_data);
      end
      tick();
      i_stall = '0;
      i_flush = '0;
      smp();
      checks++;
      if (o_stage_valid !== 4'h0 || o_occupancy !== 3'd0) begin
         errors++;
         $display("FAIL fbs_after: got sv=%0h occ=%0d, expected sv=0 occ=0", o_stage_valid, o_occupancy);
      end
      drain("fbs");
   endtask

   task automatic test_async_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         i_valid = 1'b1;
         i_data  = 32'hE0 + DATA_W'(i);
         smp();
      end
      checks++;
      if (o_occupancy !== 3'd2) begin
         errors++;
         $display("FAIL areset_pre: got occ=%0d, expected 2", o_occupancy);
      end
      tick();
      i_valid = 1'b0;
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_stage_valid !== 4'h0 || o_occupancy !== 3'd0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_now: got v=%0b sv=%0h occ=%0d r=%0b, expected 0 0 0 1",
                  o_valid, o_stage_valid, o_occupancy, o_ready);
      end
      q.delete();
      #2;
      i_reset = 1'b1;
      tick();
      i_valid = 1'b1;
      i_data  = 32'hF0;
      for (int c = 0; c < 5; c++) begin
         smp();
         checks++;
         if (o_valid !== (c == 4)) begin
            errors++;
            $display("FAIL areset_latency[%0d]: got %0b, expected %0b", c, o_valid, (c == 4));
         end
         tick();
         i_valid = 1'b0;
      end
      drain("areset");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_backpressure();
      test_flush_beats_stall();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
